vospi_sclk_gen: RTL
===================

Name: vospi_sclk_gen

Overview:
Synthesizable SPI clock and chip-select timing generator for the VoSPI master. It runs directly from the simulation/system clock and converts it into Lepton-compatible SPI mode-3 timing: SCLK idles high and the master samples MISO on the SCLK rising edge. Per-bit sample strobes go downstream to the shift/packet logic. It is the first synthesizable consumer of the testbench clock generator's output.

Parameters:
div_p, 4, SCLK half-period in clk_i cycles (>=1); SCLK frequency = f(clk_i)/(2*div_p)
cs_setup_p, 2, clk_i cycles cs_n_o is low before the first SCLK falling edge (>=1)
cs_hold_p, 2, clk_i cycles cs_n_o stays low after the last SCLK rising edge phase (>=1)
cnt_width_p, 16, width of num_bits_i and bit_count_o

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
start_v_i  in  1  transaction request valid
ready_o  out  1  generator idle, can accept a request
num_bits_i  in  cnt_width_p  number of SCLK cycles in the transaction; sampled at handshake
abort_i  in  1  finish the current bit, then end the transaction
sclk_o  out  1  SPI clock; idle level is 1
cs_n_o  out  1  SPI chip select, active low
sample_o  out  1  one-cycle pulse; downstream samples MISO this cycle
bit_count_o  out  cnt_width_p  number of bits completed in the current transaction
done_o  out  1  one-cycle pulse when the transaction ends
pause_i  in  1  see Optional Feature; present only when the macro is defined

Behaviour:
- Interface: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset (asynchronous, immediate, including mid-transaction): state IDLE, sclk_o=1, cs_n_o=1, ready_o=1, sample_o=0, done_o=0, bit_count_o=0. No partial-transaction indication is produced.
- All outputs are registered.
- Handshake: a request is accepted on a clk_i edge where start_v_i & ready_o. Call this edge 0.
- Elaboration: if div_p, cs_setup_p or cs_hold_p is < 1, issue $error and $finish.
- IDLE: ready_o=1, cs_n_o=1, sclk_o=1.
  - On accept with num_bits_i != 0: latch the bit count, clear bit_count_o, go to SETUP.
  - On accept with num_bits_i == 0: no CS assertion; done_o=1 on the cycle after edge 0; stay IDLE.
- SETUP: cs_n_o=0 from the cycle after edge 0; ready_o=0; sclk_o=1. Lasts cs_setup_p cycles, then LOW.
- LOW: sclk_o=0 for div_p cycles, then HIGH.
- HIGH: sclk_o=1 for div_p cycles.
  - sample_o=1 only on the first cycle of HIGH; bit_count_o increments in that same cycle.
  - At the end of HIGH: if bit_count_o == latched count, or abort was seen, go to HOLD; otherwise go to LOW.
- HOLD: cs_n_o=0, sclk_o=1 for cs_hold_p cycles, then IDLE.
- First IDLE cycle after HOLD: cs_n_o=1, ready_o=1, done_o=1. bit_count_o holds its final value until the next accept.
- A new request may be accepted in that same done_o cycle.
- Timing: cs_n_o is low for exactly cs_setup_p + 2*div_p*N + cs_hold_p cycles. sample_o pulses are exactly 2*div_p cycles apart.
- Abort:
  - abort_i is sticky-latched while in SETUP/LOW/HIGH and cleared in IDLE.
  - In SETUP, abort goes to HOLD at the end of SETUP with no SCLK edges.
  - In LOW/HIGH, the current bit completes (its sample_o is issued), then HOLD.
  - abort_i is ignored in IDLE and HOLD.
- Simultaneous events: abort on the last bit gives the same result as normal completion. start_v_i while ready_o=0 is ignored (no queuing).
- bit_count_o saturates at the latched count; no wrap.

Optional Feature:
Macro VOSPI_SCLK_PAUSE_EN.
- Defined: the pause_i port exists. If pause_i=1 at the end of a HIGH phase that would go to LOW, the block stays in HIGH with sclk_o=1, cs_n_o=0 and no sample_o until pause_i=0. The next LOW starts the cycle after deassertion. Pause does not apply at transaction end; abort still takes effect during pause. This lets a full downstream buffer stall the link.
- Undefined: there is no pause_i port, and HIGH always lasts exactly div_p cycles.

Test Plan:
- Defaults (div_p=4, cs_setup_p=2, cs_hold_p=2), one request with N=3 -> cs_n_o low 28 cycles; 3 sample_o pulses 8 cycles apart; bit_count_o=3; done_o 1 cycle after cs_n_o rises.
- div_p=1, N=1 -> sclk_o low 1 cycle, high 1 cycle; cs_n_o low 6 cycles; ready_o back high with done_o.
- N=0 request -> cs_n_o stays 1, sclk_o never toggles, done_o pulses on the cycle after accept.
- N=10 with abort_i pulsed during bit 4's LOW phase -> exactly 4 sample_o pulses, bit_count_o=4, then HOLD 2 cycles and done_o.
- reset_i asserted mid-HIGH of bit 2 (between clock edges) -> cs_n_o=1, sclk_o=1, bit_count_o=0 immediately; a new request after release behaves normally.
- VOSPI_SCLK_PAUSE_EN defined, N=3, pause_i held 5 cycles at the end of bit 1 -> sclk_o high 4+5 cycles; cs_n_o low 33 cycles; 3 sample_o pulses total.

Source files
------------

// File: rtl/vospi_sclk_gen.sv
// vospi_sclk_gen: SPI mode-3 SCLK/CS_N timing generator with per-bit MISO sample strobes; VOSPI_SCLK_PAUSE_EN adds a pause_i link stall.
// All outputs registered, CS_N falls the cycle after accept; start_v_i is not queued while ready_o=0.
module vospi_sclk_gen #(
   parameter int div_p       = 4,
   parameter int cs_setup_p  = 2,
   parameter int cs_hold_p   = 2,
   parameter int cnt_width_p = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_v_i,
   output logic                   ready_o,
   input  logic [cnt_width_p-1:0] num_bits_i,
   input  logic                   abort_i,
`ifdef VOSPI_SCLK_PAUSE_EN
   input  logic                   pause_i,
`endif
   output logic                   sclk_o,
   output logic                   cs_n_o,
   output logic                   sample_o,
   output logic [cnt_width_p-1:0] bit_count_o,
   output logic                   done_o
);

   if (div_p < 1 || cs_setup_p < 1 || cs_hold_p < 1) begin : g_bad_param
      $error("vospi_sclk_gen: div_p, cs_setup_p and cs_hold_p must all be >= 1");
   end

   localparam int MAX_P = (div_p > cs_setup_p)
                        ? ((div_p > cs_hold_p) ? div_p : cs_hold_p)
                        : ((cs_setup_p > cs_hold_p) ? cs_setup_p : cs_hold_p);
   localparam int PH_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [PH_W-1:0] DIV_LAST   = PH_W'(div_p - 1);
   localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(cs_setup_p - 1);
   localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(cs_hold_p - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOW,
      S_HIGH,
      S_HOLD
   } state_t;

   state_t                 r_state;
   logic [PH_W-1:0]        r_ph;
   logic [cnt_width_p-1:0] r_nbits;
   logic [cnt_width_p-1:0] r_bitcnt;
   logic                   r_abort;
   logic                   r_sclk;
   logic                   r_cs_n;
   logic                   r_ready;
   logic                   r_sample;
   logic                   r_done;

   state_t                 w_state_nxt;
   logic [PH_W-1:0]        w_ph_nxt;
   logic [cnt_width_p-1:0] w_nbits_nxt;
   logic [cnt_width_p-1:0] w_bitcnt_nxt;
   logic                   w_abort_nxt;
   logic                   w_abort_seen;
   logic                   w_sample_nxt;
   logic                   w_done_nxt;
   logic                   w_pause;

`ifdef VOSPI_SCLK_PAUSE_EN
   assign w_pause = pause_i;
`else
   assign w_pause = 1'b0;
`endif

   assign w_abort_seen = r_abort | abort_i;

   always_comb begin
      w_state_nxt  = r_state;
      w_ph_nxt     = r_ph + PH_W'(1);
      w_nbits_nxt  = r_nbits;
      w_bitcnt_nxt = r_bitcnt;
      w_abort_nxt  = w_abort_seen;
      w_sample_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_abort_nxt = 1'b0;
            w_ph_nxt    = '0;
            if (start_v_i) begin
               w_nbits_nxt  = num_bits_i;
               w_bitcnt_nxt = '0;
               if (num_bits_i == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            if (r_ph == SETUP_LAST) begin
               w_ph_nxt    = '0;
               w_state_nxt = w_abort_seen ? S_HOLD : S_LOW;
            end
         end
         S_LOW: begin
            // Rising SCLK edge: the sample strobe and the bit count move together.
            if (r_ph == DIV_LAST) begin
               w_ph_nxt     = '0;
               w_state_nxt  = S_HIGH;
               w_sample_nxt = 1'b1;
               if (r_bitcnt != r_nbits) begin
                  w_bitcnt_nxt = r_bitcnt + cnt_width_p'(1);
               end
            end
         end
         S_HIGH: begin
            if (r_ph == DIV_LAST) begin
               if ((r_bitcnt == r_nbits) || w_abort_seen) begin
                  w_ph_nxt    = '0;
                  w_state_nxt = S_HOLD;
               end else if (w_pause) begin
                  w_ph_nxt = r_ph;
               end else begin
                  w_ph_nxt    = '0;
                  w_state_nxt = S_LOW;
               end
            end
         end
         S_HOLD: begin
            w_abort_nxt = 1'b0;
            if (r_ph == HOLD_LAST) begin
               w_ph_nxt    = '0;
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_ph_nxt    = '0;
            w_abort_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state  <= S_IDLE;
         r_ph     <= '0;
         r_nbits  <= '0;
         r_bitcnt <= '0;
         r_abort  <= 1'b0;
         r_sclk   <= 1'b1;
         r_cs_n   <= 1'b1;
         r_ready  <= 1'b1;
         r_sample <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ph     <= w_ph_nxt;
         r_nbits  <= w_nbits_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_abort  <= w_abort_nxt;
         r_sclk   <= (w_state_nxt != S_LOW);
         r_cs_n   <= (w_state_nxt == S_IDLE);
         r_ready  <= (w_state_nxt == S_IDLE);
         r_sample <= w_sample_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign sclk_o      = r_sclk;
   assign cs_n_o      = r_cs_n;
   assign ready_o     = r_ready;
   assign sample_o    = r_sample;
   assign done_o      = r_done;
   assign bit_count_o = r_bitcnt;

endmodule
